// File: rtl/pipe_reg_skid_pkg.sv
// Shared pipeline definitions: stage-register state encoding and default widths.
package pipe_reg_skid_pkg;

  localparam int unsigned DEF_DATA_W = 158;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } skid_state_e;

  function automatic logic [1:0] occ_of(input skid_state_e s);
    case (s)
      ST_FULL: occ_of = 2'd1;
      ST_SKID: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_reg_skid.sv
// Two-entry pipeline stage register with a skid slot so that in_ready is a pure
// register output, plus a saturating count of back-pressured cycles.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | no entry held, main = BUBBLE_VAL, ready for input
//   ST_FULL  | one entry in main, still ready for input
//   ST_SKID  | main and skid both hold entries, input refused
module pipe_reg_skid
  import pipe_reg_skid_pkg::*;
#(
  parameter int unsigned       DATA_W     = DEF_DATA_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int unsigned       CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push, pop;

  assign in_ready    = (state_q != ST_SKID);
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_data    = main_q;
  assign occupancy   = occ_of(state_q);
  assign stall_count = cnt_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;

    if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_FULL;
          main_d  = in_data;
        end
      end
      ST_FULL: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          state_d = ST_SKID;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_VAL;
        end
      end
      ST_SKID: begin
        if (pop) begin
          state_d = ST_FULL;
          main_d  = skid_q;
          skid_d  = BUBBLE_VAL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        main_d  = BUBBLE_VAL;
        skid_d  = BUBBLE_VAL;
      end
    endcase

    // Flush overrides any same-cycle push, pop or stall increment.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
      cnt_d   = '0;
    end
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed-vector bench for pipe_reg_skid with a narrow payload, 3-bit stall
// counter and a non-zero bubble value.
module tb_pipe_reg_skid;

  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 3;
  localparam logic [7:0]  BUB = 8'hEE;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_count;

  int checks   = 0;
  int failures = 0;

  pipe_reg_skid #(.DATA_W(DW), .BUBBLE_VAL(BUB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fl, iv, ordy;
    logic [7:0] d;
    logic       ov, ir;
    logic [7:0] od;
    logic [1:0] occ;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic fl, logic iv, logic [7:0] d, logic ordy,
                              logic ov, logic ir, logic [7:0] od,
                              logic [1:0] occ, logic [2:0] st);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ov = ov; v.ir = ir; v.od = od; v.occ = occ; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic ir,
                         input logic [7:0] od, input logic [1:0] occ, input logic [2:0] st);
    chk({tag, ".out_valid"},   32'(out_valid),   32'(ov));
    chk({tag, ".in_ready"},    32'(in_ready),    32'(ir));
    chk({tag, ".out_data"},    32'(out_data),    32'(od));
    chk({tag, ".occupancy"},   32'(occupancy),   32'(occ));
    chk({tag, ".stall_count"}, 32'(stall_count), 32'(st));
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [7:0] d, input logic ordy);
    flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] stream[100];

  initial begin
    //            fl iv  d      ordy  ov ir od     occ st
    vecs[0]  = mk(0, 1, 8'hA1, 1,    1, 1, 8'hA1, 1,  0); // push into EMPTY
    vecs[1]  = mk(0, 0, 8'h00, 1,    0, 1, BUB,   0,  0); // pop -> EMPTY
    vecs[2]  = mk(0, 1, 8'hB1, 0,    1, 1, 8'hB1, 1,  0);
    vecs[3]  = mk(0, 1, 8'hB2, 0,    1, 0, 8'hB1, 2,  1); // push only -> SKID
    vecs[4]  = mk(0, 1, 8'hB3, 0,    1, 0, 8'hB1, 2,  2); // refused in SKID
    vecs[5]  = mk(0, 0, 8'h00, 1,    1, 1, 8'hB2, 1,  2); // B1 consumed
    vecs[6]  = mk(0, 0, 8'h00, 1,    0, 1, BUB,   0,  2); // B2 consumed
    vecs[7]  = mk(0, 1, 8'hC1, 0,    1, 1, 8'hC1, 1,  2);
    vecs[8]  = mk(0, 1, 8'hC2, 1,    1, 1, 8'hC2, 1,  2); // push & pop in FULL
    vecs[9]  = mk(0, 1, 8'hC3, 0,    1, 0, 8'hC2, 2,  3);
    vecs[10] = mk(1, 1, 8'hC4, 1,    0, 1, BUB,   0,  0); // flush in SKID
    vecs[11] = mk(0, 0, 8'h00, 0,    0, 1, BUB,   0,  0);
    vecs[12] = mk(0, 1, 8'hD1, 0,    1, 1, 8'hD1, 1,  0);
    vecs[13] = mk(0, 1, 8'hD2, 0,    1, 0, 8'hD1, 2,  1);
    vecs[14] = mk(0, 0, 8'h00, 1,    1, 1, 8'hD2, 1,  1);
    vecs[15] = mk(0, 0, 8'h00, 1,    0, 1, BUB,   0,  1);
    vecs[16] = mk(1, 1, 8'hE1, 1,    0, 1, BUB,   0,  0); // flush beats push
    vecs[17] = mk(0, 0, 8'h00, 0,    0, 1, BUB,   0,  0);

    rst = 1'b1;
    drive(0, 0, 8'h00, 0);
    tick();
    tick();
    chk_all("reset", 0, 1, BUB, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].ir, vecs[i].od,
              vecs[i].occ, vecs[i].st);
    end

    // Back-to-back streaming: each payload appears exactly one cycle after it is offered.
    for (int i = 0; i < 100; i++) stream[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 100; i++) begin
      drive(0, 1, stream[i], 1);
      tick();
      chk($sformatf("stream%0d.data", i), 32'(out_data), 32'(stream[i]));
      chk($sformatf("stream%0d.occ", i), 32'(occupancy), 32'd1);
    end
    drive(0, 0, 8'h00, 1);
    tick();
    chk_all("stream_drain", 0, 1, BUB, 0, 0);

    // Stall counter saturation with a 3-bit counter.
    drive(0, 1, 8'hF1, 0);
    tick();
    chk_all("sat_load", 1, 1, 8'hF1, 1, 0);
    drive(0, 0, 8'h00, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("sat%0d.stall", k), 32'(stall_count), (k > 7) ? 32'd7 : 32'(k));
      chk($sformatf("sat%0d.data", k), 32'(out_data), 32'hF1);
    end

    // Asynchronous reset between clock edges, sampled before the next edge.
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 1, BUB, 0, 0);
    #2;
    rst = 1'b0;
    drive(0, 1, 8'h91, 1);
    tick();
    chk_all("after_rst", 1, 1, 8'h91, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
